local_bp_table_sequencer: RTL and testbench

- Owns the single shared port of each local-predictor table: the local history table (LHT, indexed by PC) and the local pattern table (LPT, indexed by history).
- Serialises front-end lookups and retire-side updates onto those ports and buffers resolved-branch updates in a small FIFO.
- Arbitrates lookup vs update with starvation protection and zero-initialises both tables after reset.
- Sits between fetch/retire and the table storage macros; the tables themselves are external, with a 1-cycle synchronous read.

---
 rtl/local_bp_table_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_local_bp_table_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_bp_table_sequencer.sv
// Local-predictor table port sequencer: zero sweep after reset, 2-cycle lookups, 3-cycle FIFO-buffered updates.
// Lookups are refused while the update FIFO is full or starved; upd_ready drops only when the FIFO is full.
module local_bp_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign head  = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

module local_bp_table_sequencer #(
  parameter int PC_W       = 10,
  parameter int HIST_W     = 10,
  parameter int CTR_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              lookup_ready,
  output logic              pred_valid,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic              lht_en,
  output logic              lht_we,
  output logic [PC_W-1:0]   lht_addr,
  output logic [HIST_W-1:0] lht_wdata,
  input  logic [HIST_W-1:0] lht_rdata,
  output logic              lpt_en,
  output logic              lpt_we,
  output logic [HIST_W-1:0] lpt_addr,
  output logic [CTR_W-1:0]  lpt_wdata,
  input  logic [CTR_W-1:0]  lpt_rdata,
  output logic              busy_init
);
  localparam int SWEEP_W = (PC_W > HIST_W) ? PC_W : HIST_W;
  localparam int SC_W    = $clog2(STARVE_MAX + 1);
  localparam logic [SWEEP_W:0]  LHT_LIM = (SWEEP_W+1)'(1) << PC_W;
  localparam logic [SWEEP_W:0]  LPT_LIM = (SWEEP_W+1)'(1) << HIST_W;
  localparam logic [CTR_W-1:0]  CTR_MAX = '1;

  localparam logic [2:0] INIT    = 3'd0;
  localparam logic [2:0] IDLE    = 3'd1;
  localparam logic [2:0] LK_HIST = 3'd2;
  localparam logic [2:0] LK_CTR  = 3'd3;
  localparam logic [2:0] UP_HIST = 3'd4;
  localparam logic [2:0] UP_CTR  = 3'd5;
  localparam logic [2:0] UP_WR   = 3'd6;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [SWEEP_W-1:0] sweep;
  logic [SC_W-1:0]    starve_cnt;
  logic [HIST_W-1:0]  hist;
  logic [CTR_W-1:0]   ctr;
  logic [CTR_W-1:0]   ctr_new;
  logic               taken_hold;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_push;
  logic               fifo_pop;
  logic [PC_W:0]      fifo_head;
  logic [PC_W-1:0]    head_pc;
  logic               head_taken;
  logic               force_upd;
  logic               lookup_go;
  logic               lht_in_range;
  logic               lpt_in_range;
  logic               lht_en_c;
  logic               lht_we_c;
  logic               lpt_en_c;
  logic               lpt_we_c;

  assign fifo_push = upd_valid && !fifo_full;
  assign fifo_pop  = (state == UP_WR);
  assign upd_ready = !fifo_full;

  local_bp_fifo #(
    .W     (PC_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({upd_pc, upd_taken}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign head_pc    = fifo_head[PC_W:1];
  assign head_taken = fifo_head[0];

  assign force_upd    = fifo_full || (!fifo_empty && (starve_cnt == SC_W'(STARVE_MAX)));
  assign lookup_ready = (state == IDLE) && !force_upd;
  assign lookup_go    = lookup_valid && lookup_ready;

  assign lht_in_range = ({1'b0, sweep} < LHT_LIM);
  assign lpt_in_range = ({1'b0, sweep} < LPT_LIM);

  assign ctr_new = head_taken ? ((ctr == CTR_MAX) ? ctr : ctr + 1'b1)
                              : ((ctr == '0) ? ctr : ctr - 1'b1);

  always_comb begin
    state_nxt = state;
    lht_en_c  = 1'b0;
    lht_we_c  = 1'b0;
    lht_addr  = '0;
    lht_wdata = '0;
    lpt_en_c  = 1'b0;
    lpt_we_c  = 1'b0;
    lpt_addr  = '0;
    lpt_wdata = '0;
    case (state)
      INIT: begin
        lht_en_c = lht_in_range;
        lht_we_c = lht_in_range;
        lht_addr = sweep[PC_W-1:0];
        lpt_en_c = lpt_in_range;
        lpt_we_c = lpt_in_range;
        lpt_addr = sweep[HIST_W-1:0];
        if (sweep == {SWEEP_W{1'b1}}) state_nxt = IDLE;
      end
      IDLE: begin
        if (lookup_go) begin
          lht_en_c  = 1'b1;
          lht_addr  = lookup_pc;
          state_nxt = LK_HIST;
        end else if (!fifo_empty) begin
          lht_en_c  = 1'b1;
          lht_addr  = head_pc;
          state_nxt = UP_HIST;
        end
      end
      LK_HIST: begin
        lpt_en_c  = 1'b1;
        lpt_addr  = lht_rdata;
        state_nxt = LK_CTR;
      end
      LK_CTR: state_nxt = IDLE;
      UP_HIST: begin
        lpt_en_c  = 1'b1;
        lpt_addr  = lht_rdata;
        state_nxt = UP_CTR;
      end
      UP_CTR: state_nxt = UP_WR;
      UP_WR: begin
        lht_en_c  = 1'b1;
        lht_we_c  = 1'b1;
        lht_addr  = head_pc;
        lht_wdata = {hist[HIST_W-2:0], head_taken};
        lpt_en_c  = 1'b1;
        lpt_we_c  = 1'b1;
        lpt_addr  = hist;
        lpt_wdata = ctr_new;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  // Table strobes are held off while reset is asserted so an aborted update never lands.
  assign lht_en = lht_en_c && reset;
  assign lht_we = lht_we_c && reset;
  assign lpt_en = lpt_en_c && reset;
  assign lpt_we = lpt_we_c && reset;

  assign busy_init  = (state == INIT);
  assign pred_valid = (state == LK_CTR);
  assign pred_taken = pred_valid ? lpt_rdata[CTR_W-1] : taken_hold;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= INIT;
      sweep      <= '0;
      starve_cnt <= '0;
      hist       <= '0;
      ctr        <= '0;
      taken_hold <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == INIT) sweep <= sweep + 1'b1;
      if (state == IDLE) begin
        if (lookup_go)
          starve_cnt <= fifo_empty ? '0 : starve_cnt + 1'b1;
        else if (!fifo_empty)
          starve_cnt <= '0;
      end
      if (state == UP_HIST) hist <= lht_rdata;
      if (state == UP_CTR)  ctr <= lpt_rdata;
      if (state == LK_CTR)  taken_hold <= lpt_rdata[CTR_W-1];
    end
  end
endmodule

// File: tb/tb_local_bp_table_sequencer.sv
// Bench for local_bp_table_sequencer: table memories with 1-cycle read, a table-level reference
// model with an in-order update queue, directed vectors, arbitration corner cases and random traffic.
module tb_local_bp_table_sequencer;
  localparam int PC_W = 10, HIST_W = 10, CTR_W = 3, NENT = 1024;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic lookup_valid = 1'b0;
  logic [PC_W-1:0] lookup_pc = '0;
  logic lookup_ready, pred_valid, pred_taken;
  logic upd_valid = 1'b0;
  logic [PC_W-1:0] upd_pc = '0;
  logic upd_taken = 1'b0;
  logic upd_ready;
  logic lht_en, lht_we, lpt_en, lpt_we, busy_init;
  logic [PC_W-1:0] lht_addr;
  logic [HIST_W-1:0] lht_wdata, lpt_addr;
  logic [HIST_W-1:0] lht_rdata;
  logic [CTR_W-1:0] lpt_wdata, lpt_rdata;

  always #5 clock = ~clock;

  local_bp_table_sequencer dut (
    .clock(clock), .reset(reset),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .lht_en(lht_en), .lht_we(lht_we), .lht_addr(lht_addr), .lht_wdata(lht_wdata), .lht_rdata(lht_rdata),
    .lpt_en(lpt_en), .lpt_we(lpt_we), .lpt_addr(lpt_addr), .lpt_wdata(lpt_wdata), .lpt_rdata(lpt_rdata),
    .busy_init(busy_init)
  );

  logic [HIST_W-1:0] lht_mem [NENT];
  logic [CTR_W-1:0]  lpt_mem [NENT];
  logic scramble = 1'b0;

  always @(posedge clock) begin
    if (scramble) begin
      for (int i = 0; i < NENT; i++) begin
        lht_mem[i] <= 10'h2A5;
        lpt_mem[i] <= 3'd5;
      end
    end else begin
      if (lht_en) begin
        if (lht_we) lht_mem[lht_addr] <= lht_wdata;
        else        lht_rdata <= lht_mem[lht_addr];
      end
      if (lpt_en) begin
        if (lpt_we) lpt_mem[lpt_addr] <= lpt_wdata;
        else        lpt_rdata <= lpt_mem[lpt_addr];
      end
    end
  end

  int checks = 0, failures = 0, cyc = 0;
  int ref_lht [NENT];
  int ref_lpt [NENT];
  typedef struct { int pc; int taken; } upd_t;
  typedef struct { int exp; int cyc; } prd_t;
  upd_t ref_q [$];
  prd_t prd_q [$];
  int init_idx = 0, init_bad = 0, busy_cycles = 0;

  typedef struct { bit is_lk; int pc; bit taken; bit exp; } vec_t;
  vec_t vecs [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int sat_next(input int c, input int t);
    int n;
    n = t ? c + 1 : c - 1;
    if (n > (1 << CTR_W) - 1) n = (1 << CTR_W) - 1;
    if (n < 0) n = 0;
    return n;
  endfunction

  task automatic monitor();
    upd_t u;
    prd_t p;
    int h, nh, nc;
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset) begin
        init_idx = 0;
      end else begin
        if (busy_init) begin
          busy_cycles++;
          if (!(lht_en && lht_we && lpt_en && lpt_we) || lht_addr != init_idx[9:0] ||
              lpt_addr != init_idx[9:0] || lht_wdata != 0 || lpt_wdata != 0 || lookup_ready)
            init_bad++;
          init_idx++;
        end else begin
          if ((lht_en && lht_we) || (lpt_en && lpt_we)) begin
            chk("write_has_pending_update", 32'(ref_q.size() > 0), 1);
            if (ref_q.size() > 0) begin
              u  = ref_q.pop_front();
              h  = ref_lht[u.pc];
              nh = (h * 2 + u.taken) % NENT;
              nc = sat_next(ref_lpt[h], u.taken);
              chk("upd_lht_we", 32'(lht_en && lht_we), 1);
              chk("upd_lht_addr", 32'(lht_addr), u.pc);
              chk("upd_lht_wdata", 32'(lht_wdata), nh);
              chk("upd_lpt_we", 32'(lpt_en && lpt_we), 1);
              chk("upd_lpt_addr", 32'(lpt_addr), h);
              chk("upd_lpt_wdata", 32'(lpt_wdata), nc);
              ref_lht[u.pc] = nh;
              ref_lpt[h] = nc;
            end
          end
          if (lookup_valid && lookup_ready)
            prd_q.push_back('{exp: int'(ref_lpt[ref_lht[lookup_pc]] >= (1 << (CTR_W - 1))), cyc: cyc});
          if (pred_valid) begin
            chk("pred_has_pending_lookup", 32'(prd_q.size() > 0), 1);
            if (prd_q.size() > 0) begin
              p = prd_q.pop_front();
              chk("pred_taken", 32'(pred_taken), p.exp);
              chk("pred_latency", cyc - p.cyc, 2);
            end
          end
        end
        if (upd_valid && upd_ready) ref_q.push_back('{pc: int'(upd_pc), taken: int'(upd_taken)});
      end
    end
  endtask

  task automatic do_reset(input bit scr);
    int n, bad;
    reset = 1'b0;
    lookup_valid = 1'b0; upd_valid = 1'b0;
    ref_q.delete(); prd_q.delete();
    for (int i = 0; i < NENT; i++) begin ref_lht[i] = 0; ref_lpt[i] = 0; end
    busy_cycles = 0; init_bad = 0;
    scramble = scr;
    bad = 0;
    repeat (3) begin
      @(negedge clock);
      if (lht_en || lht_we || lpt_en || lpt_we) bad++;
    end
    chk("rst_no_table_access", bad, 0);
    chk("rst_busy_init", 32'(busy_init), 1);
    chk("rst_lookup_ready", 32'(lookup_ready), 0);
    chk("rst_pred_valid", 32'(pred_valid), 0);
    chk("rst_pred_taken", 32'(pred_taken), 0);
    chk("rst_upd_ready", 32'(upd_ready), 1);
    scramble = 1'b0;
    @(posedge clock); #1 reset = 1'b1;
    n = 0;
    @(negedge clock);
    while (busy_init && n < 1100) begin @(negedge clock); n++; end
    chk("init_busy_cycles", busy_cycles, 1024);
    chk("init_sweep_writes", init_bad, 0);
    chk("post_init_busy", 32'(busy_init), 0);
    chk("post_init_lookup_ready", 32'(lookup_ready), 1);
    bad = 0;
    for (int i = 0; i < NENT; i++) if (lht_mem[i] != 0 || lpt_mem[i] != 0) bad++;
    chk("init_tables_zero", bad, 0);
    @(posedge clock); #1;
  endtask

  task automatic do_push(input int pc, input int t);
    int n;
    upd_valid = 1'b1; upd_pc = 10'(pc); upd_taken = 1'(t);
    n = 0;
    @(negedge clock);
    while (!upd_ready && n < 100) begin @(negedge clock); n++; end
    chk("push_accept_timeout", 32'(n < 100), 1);
    @(posedge clock); #1 upd_valid = 1'b0;
  endtask

  task automatic do_lookup(input int pc, output int got);
    int n, h;
    lookup_valid = 1'b1; lookup_pc = 10'(pc);
    n = 0;
    @(negedge clock);
    while (!lookup_ready && n < 2000) begin @(negedge clock); n++; end
    chk("lookup_accept_timeout", 32'(n < 2000), 1);
    h = ref_lht[pc];
    chk("lk_lht_read", 32'(lht_en && !lht_we), 1);
    chk("lk_lht_addr", 32'(lht_addr), pc);
    @(posedge clock); #1 lookup_valid = 1'b0;
    @(negedge clock);
    chk("lk_lpt_read", 32'(lpt_en && !lpt_we), 1);
    chk("lk_lpt_addr", 32'(lpt_addr), h);
    @(negedge clock);
    chk("lk_pred_valid", 32'(pred_valid), 1);
    got = int'(pred_taken);
    @(posedge clock); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ref_q.size() != 0 || prd_q.size() != 0) && n < 1000) begin @(posedge clock); n++; end
    repeat (4) @(posedge clock);
    #1;
    chk("drain_outstanding", ref_q.size() + prd_q.size(), 0);
  endtask

  function automatic vec_t mk(input bit lk, input int pc, input bit t, input bit e);
    vec_t v;
    v.is_lk = lk; v.pc = pc; v.taken = t; v.exp = e;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=expired required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int got, grants, grant_k, wr_k, k;
    vecs[0]  = mk(1, 5, 0, 0);  vecs[1]  = mk(0, 5, 1, 0);  vecs[2]  = mk(0, 5, 1, 0);
    vecs[3]  = mk(0, 5, 1, 0);  vecs[4]  = mk(1, 5, 0, 0);  vecs[5]  = mk(0, 20, 1, 0);
    vecs[6]  = mk(1, 21, 0, 0); vecs[7]  = mk(0, 21, 1, 0); vecs[8]  = mk(0, 22, 1, 0);
    vecs[9]  = mk(1, 23, 0, 1); vecs[10] = mk(0, 23, 1, 0); vecs[11] = mk(0, 24, 1, 0);
    vecs[12] = mk(0, 25, 1, 0); vecs[13] = mk(0, 26, 1, 0); vecs[14] = mk(1, 27, 0, 1);
    vecs[15] = mk(0, 28, 0, 0); vecs[16] = mk(0, 5, 0, 0);  vecs[17] = mk(1, 5, 0, 0);
    vecs[18] = mk(1, 21, 0, 0);

    fork monitor(); join_none
    do_reset(1'b1);

    for (int i = 0; i < 19; i++) begin
      if (vecs[i].is_lk) begin
        do_lookup(vecs[i].pc, got);
        chk($sformatf("vec%0d_pred_taken", i), got, 32'(vecs[i].exp));
      end else begin
        do_push(vecs[i].pc, int'(vecs[i].taken));
        drain();
      end
      if (i == 3) begin
        chk("lht5_after_3_taken", 32'(lht_mem[5]), 32'h007);
        chk("lpt0_after_3_taken", 32'(lpt_mem[0]), 1);
        chk("lpt1_after_3_taken", 32'(lpt_mem[1]), 1);
        chk("lpt3_after_3_taken", 32'(lpt_mem[3]), 1);
      end
      if (i == 13) chk("lpt0_saturated", 32'(lpt_mem[0]), 7);
    end
    chk("lpt0_after_not_taken", 32'(lpt_mem[0]), 6);
    chk("lpt7_floor", 32'(lpt_mem[7]), 0);
    chk("lht5_final", 32'(lht_mem[5]), 32'h00E);

    // One queued update against a continuous lookup stream.
    lookup_valid = 1'b1; lookup_pc = 10'd9;
    k = 0;
    @(negedge clock);
    while (!lookup_ready && k < 50) begin @(negedge clock); k++; end
    @(posedge clock); #1 upd_valid = 1'b1; upd_pc = 10'd40; upd_taken = 1'b1;
    @(negedge clock); chk("starve_push_ready", 32'(upd_ready), 1);
    @(posedge clock); #1 upd_valid = 1'b0;
    grants = 0; grant_k = -1; wr_k = -1;
    for (int j = 0; j < 60 && wr_k < 0; j++) begin
      @(negedge clock);
      if (lookup_valid && lookup_ready) grants++;
      if (lht_en && !lht_we && !lookup_ready) grant_k = j;
      if (lht_en && lht_we) wr_k = j;
    end
    chk("starve_lookup_grants", grants, 4);
    chk("starve_update_cycles", wr_k - grant_k, 3);
    @(negedge clock); chk("starve_lookup_resumes", 32'(lookup_valid && lookup_ready), 1);
    @(posedge clock); #1 lookup_valid = 1'b0;
    drain();

    // Fill the FIFO while lookups keep the port busy.
    lookup_valid = 1'b1; lookup_pc = 10'd11;
    do_push(50, 1); do_push(51, 0); do_push(52, 1); do_push(53, 1);
    @(negedge clock); chk("full_upd_ready_low", 32'(upd_ready), 0);
    k = 0;
    while (!(lht_en && !lht_we) && k < 40) begin @(negedge clock); k++; end
    chk("full_grant_seen", 32'(k < 40), 1);
    chk("full_grant_lookup_refused", 32'(lookup_ready), 0);
    chk("full_grant_head_pc", 32'(lht_addr), 50);
    k = 0;
    while (!(lht_en && lht_we) && k < 40) begin @(negedge clock); k++; end
    chk("full_write_upd_ready", 32'(upd_ready), 0);
    @(negedge clock); chk("full_after_pop_upd_ready", 32'(upd_ready), 1);
    @(posedge clock); #1 lookup_valid = 1'b0;
    drain();

    // Randomized traffic over a small PC set to provoke hazards.
    for (int j = 0; j < 3000; j++) begin
      lookup_valid = 1'($urandom_range(0, 1));
      lookup_pc    = 10'($urandom_range(0, 15));
      upd_valid    = ($urandom_range(0, 2) == 0);
      upd_pc       = 10'($urandom_range(0, 15));
      upd_taken    = 1'($urandom_range(0, 1));
      @(posedge clock); #1;
    end
    lookup_valid = 1'b0; upd_valid = 1'b0;
    drain();

    // Reset landing in UP_CTR must abort the update.
    do_push(60, 1);
    k = 0;
    @(negedge clock);
    while (!(lpt_en && !lpt_we) && k < 20) begin @(negedge clock); k++; end
    chk("abort_up_hist_seen", 32'(k < 20), 1);
    @(posedge clock); #1 reset = 1'b0;
    do_reset(1'b0);
    repeat (10) @(posedge clock);
    #1;
    chk("abort_fifo_empty", ref_q.size(), 0);
    chk("abort_lht60_zero", 32'(lht_mem[60]), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
